// File: rtl/i2s_pkg.sv
// Shared constants and receiver state type for the I2S receiver.
package i2s_pkg;

    parameter int unsigned SAMPLE_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        StSeek,
        StLeft,
        StRight
    } i2s_state_e;

endpackage

// File: rtl/i2s_sync.sv
// Two-flop synchronizer with a rising-edge detector on the synchronized level.
module i2s_sync (
    input  logic clk_in,
    input  logic reset_in,
    input  logic async_in,
    output logic sync_out,
    output logic rise_out
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], async_in};
            prev_q <= sync_q[1];
        end
    end

    assign sync_out = sync_q[1];
    assign rise_out = sync_q[1] & ~prev_q;

endmodule

// File: rtl/i2s_receiver.sv
// Philips I2S receiver: deserializes left/right slots into a frame register with
// valid/ready handoff, sticky overrun and short-slot error flags.
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = SAMPLE_WIDTH_DEFAULT
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic                    i2s_bclk_in,
    input  logic                    i2s_ws_in,
    input  logic                    i2s_d_in,
    output logic [SAMPLE_WIDTH-1:0] sample_l_out,
    output logic [SAMPLE_WIDTH-1:0] sample_r_out,
    output logic                    sample_valid_out,
    input  logic                    sample_ready_in,
    output logic                    overrun_out,
    output logic                    frame_err_out,
    input  logic                    status_clr_in
);

    localparam int unsigned CntW = $clog2(SAMPLE_WIDTH + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(SAMPLE_WIDTH);

    logic bclk_sync;
    logic bit_evt;

    i2s_sync u_bclk_sync (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .async_in (i2s_bclk_in),
        .sync_out (bclk_sync),
        .rise_out (bit_evt)
    );

    // Same two-flop depth as the bclk path so ws/d line up with the detected edge.
    logic [1:0] ws_sync_q;
    logic [1:0] d_sync_q;
    logic       ws_s;
    logic       d_s;

    assign ws_s = ws_sync_q[1];
    assign d_s  = d_sync_q[1];

    i2s_state_e              state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d, cnt_in;
    logic [SAMPLE_WIDTH-1:0] shift_q, shift_d, shift_in;
    logic [SAMPLE_WIDTH-1:0] left_q, left_d;
    logic                    prev_ws_q, prev_ws_d;
    logic [SAMPLE_WIDTH-1:0] sample_l_q, sample_l_d;
    logic [SAMPLE_WIDTH-1:0] sample_r_q, sample_r_d;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;
    logic                    frame_err_q, frame_err_d;
    logic                    boundary;
    logic                    full;
    logic                    publish;
    logic                    frame_err_set;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            ws_sync_q   <= 2'b00;
            d_sync_q    <= 2'b00;
            state_q     <= StSeek;
            cnt_q       <= '0;
            shift_q     <= '0;
            left_q      <= '0;
            prev_ws_q   <= 1'b0;
            sample_l_q  <= '0;
            sample_r_q  <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            ws_sync_q   <= {ws_sync_q[0], i2s_ws_in};
            d_sync_q    <= {d_sync_q[0], i2s_d_in};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            left_q      <= left_d;
            prev_ws_q   <= prev_ws_d;
            sample_l_q  <= sample_l_d;
            sample_r_q  <= sample_r_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Current bit folded into the slot; counter saturates so long slots keep the MSBs.
    always_comb begin
        shift_in = shift_q;
        cnt_in   = cnt_q;
        if (cnt_q < CntMax) begin
            shift_in = {shift_q[SAMPLE_WIDTH-2:0], d_s};
            cnt_in   = cnt_q + CntW'(1);
        end
    end

    assign boundary = bit_evt && (ws_s != prev_ws_q);
    assign full     = (cnt_in == CntMax);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        left_d        = left_q;
        prev_ws_d     = prev_ws_q;
        publish       = 1'b0;
        frame_err_set = 1'b0;

        if (bit_evt) begin
            prev_ws_d = ws_s;
            unique case (state_q)
                StSeek: begin
                    if (boundary && !ws_s) begin
                        state_d = StLeft;
                        cnt_d   = '0;
                        shift_d = '0;
                    end
                end
                StLeft: begin
                    if (boundary) begin
                        cnt_d   = '0;
                        shift_d = '0;
                        if (full) begin
                            left_d  = shift_in;
                            state_d = StRight;
                        end else begin
                            frame_err_set = 1'b1;
                            state_d       = StSeek;
                        end
                    end else begin
                        cnt_d   = cnt_in;
                        shift_d = shift_in;
                    end
                end
                StRight: begin
                    if (boundary) begin
                        cnt_d   = '0;
                        shift_d = '0;
                        state_d = StLeft;
                        if (full) begin
                            publish = 1'b1;
                        end else begin
                            frame_err_set = 1'b1;
                        end
                    end else begin
                        cnt_d   = cnt_in;
                        shift_d = shift_in;
                    end
                end
                default: state_d = StSeek;
            endcase
        end
    end

    always_comb begin
        sample_l_d  = publish ? left_q : sample_l_q;
        sample_r_d  = publish ? shift_in : sample_r_q;
        valid_d     = publish | (valid_q & ~sample_ready_in);
        // Set terms are OR-ed after the clear so a coincident set wins.
        overrun_d   = (publish & valid_q & ~sample_ready_in) | (overrun_q & ~status_clr_in);
        frame_err_d = frame_err_set | (frame_err_q & ~status_clr_in);
    end

    assign sample_l_out     = sample_l_q;
    assign sample_r_out     = sample_r_q;
    assign sample_valid_out = valid_q;
    assign overrun_out      = overrun_q;
    assign frame_err_out    = frame_err_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed and randomized frame-level checks of the I2S receiver against a slot-level model.
`timescale 1ns / 1ps
module tb_i2s_receiver;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         bclk = 1'b0;
    logic         ws = 1'b0;
    logic         d = 1'b0;
    logic         ready = 1'b1;
    logic         clr = 1'b0;
    logic [W-1:0] sample_l;
    logic [W-1:0] sample_r;
    logic         valid;
    logic         overrun;
    logic         frame_err;

    int n_cmp = 0;
    int n_fail = 0;
    logic pend_d = 1'b0;
    logic [31:0] got[$];
    logic [31:0] exp_q[$];

    i2s_receiver #(.SAMPLE_WIDTH(W)) dut (
        .clk_in           (clk),
        .reset_in         (reset),
        .i2s_bclk_in      (bclk),
        .i2s_ws_in        (ws),
        .i2s_d_in         (d),
        .sample_l_out     (sample_l),
        .sample_r_out     (sample_r),
        .sample_valid_out (valid),
        .sample_ready_in  (ready),
        .overrun_out      (overrun),
        .frame_err_out    (frame_err),
        .status_clr_in    (clr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Every accepted frame is recorded as {L, R}.
    always @(negedge clk) begin
        if (valid && ready) got.push_back({sample_l, sample_r});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bclk period; bclk low then high for 4 clk cycles each.
    task automatic send_event(input logic w, input logic b);
        @(negedge clk);
        ws = w;
        d  = b;
        repeat (4) @(negedge clk);
        bclk = 1'b1;
        repeat (4) @(negedge clk);
        bclk = 1'b0;
    endtask

    // ws leads data by one bit: each bit goes out one event after its slot's ws.
    task automatic push_bit(input logic w, input logic b);
        send_event(w, pend_d);
        pend_d = b;
    endtask

    task automatic send_slot(input logic w, input logic [31:0] word, input int n);
        for (int i = n - 1; i >= 0; i--) push_bit(w, word[i]);
    endtask

    task automatic send_frame(input logic [31:0] l, input int nl, input logic [31:0] r,
                              input int nr);
        send_slot(1'b0, l, nl);
        send_slot(1'b1, r, nr);
    endtask

    task automatic close_stream();
        push_bit(1'b0, 1'b0);
        repeat (6) @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check({tag, "_outs"}, {sample_l, sample_r, valid, overrun, frame_err}, '0);
        reset  = 1'b0;
        pend_d = 1'b0;
        got.delete();
    endtask

    function automatic logic [15:0] top16(input logic [31:0] word, input int n);
        logic [31:0] t;
        t = word >> (n - 16);
        return t[15:0];
    endfunction

    initial begin
        logic [31:0] lw, rw;
        int nl, nr;
        logic fe_exp;

        // Basic 16-bit frame
        ready = 1'b1;
        do_reset("rst1");
        send_slot(1'b1, 32'h0, 16);
        send_frame(32'hA55A, 16, 32'h0F0F, 16);
        close_stream();
        check("basic_cnt", got.size(), 1);
        if (got.size() > 0) check("basic_frame", got[0], 32'hA55A0F0F);
        check("basic_flags", {valid, overrun, frame_err}, 3'b000);
        check("basic_hold", {sample_l, sample_r}, 32'hA55A0F0F);

        // Stream starting mid right slot
        do_reset("rst2");
        send_slot(1'b1, 32'h55, 7);
        send_frame(32'h1234, 16, 32'h8001, 16);
        close_stream();
        check("mid_cnt", got.size(), 1);
        if (got.size() > 0) check("mid_frame", got[0], 32'h12348001);
        check("mid_flags", {overrun, frame_err}, 2'b00);

        // 32-bit slots keep the upper 16 bits
        do_reset("rst3");
        send_slot(1'b1, 32'h0, 32);
        send_frame(32'hCAFE0001, 32, 32'h7FFF8000, 32);
        close_stream();
        check("long_cnt", got.size(), 1);
        if (got.size() > 0) check("long_frame", got[0], 32'hCAFE7FFF);
        check("long_err", frame_err, 1'b0);

        // Overrun with ready low
        do_reset("rst4");
        ready = 1'b0;
        send_slot(1'b1, 32'h0, 16);
        send_frame(32'h1111, 16, 32'h2222, 16);
        send_frame(32'h3333, 16, 32'h4444, 16);
        close_stream();
        check("ovr_valid", valid, 1'b1);
        check("ovr_data", {sample_l, sample_r}, 32'h33334444);
        check("ovr_flag", overrun, 1'b1);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("ovr_clr", overrun, 1'b0);
        check("ovr_still_valid", valid, 1'b1);
        ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ovr_accept", valid, 1'b0);
        check("ovr_got", got.size(), 1);

        // Short left slot
        do_reset("rst5");
        send_slot(1'b1, 32'h0, 16);
        send_frame(32'h5A, 8, 32'h1234, 16);
        send_frame(32'h5555, 16, 32'hAAAA, 16);
        close_stream();
        check("short_err", frame_err, 1'b1);
        check("short_cnt", got.size(), 1);
        if (got.size() > 0) check("short_frame", got[0], 32'h5555AAAA);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("short_clr", frame_err, 1'b0);

        // Reset during a left slot
        do_reset("rst6");
        send_slot(1'b1, 32'h0, 16);
        send_frame(32'h0102, 16, 32'h0304, 16);
        send_slot(1'b0, 32'hFFFF, 10);
        check("pre_rst_frame", {sample_l, sample_r}, 32'h01020304);
        do_reset("mid_rst");
        send_slot(1'b1, 32'h0, 16);
        send_frame(32'h6789, 16, 32'hABCD, 16);
        close_stream();
        check("post_rst_cnt", got.size(), 1);
        if (got.size() > 0) check("post_rst_frame", got[0], 32'h6789ABCD);

        // Random slot lengths, including short slots
        do_reset("rst7");
        exp_q.delete();
        fe_exp = 1'b0;
        send_slot(1'b1, 32'h0, 16);
        for (int f = 0; f < 12; f++) begin
            lw = $urandom;
            rw = $urandom;
            nl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(8, 15))
                                             : int'($urandom_range(16, 32));
            nr = ($urandom_range(0, 4) == 0) ? int'($urandom_range(8, 15))
                                             : int'($urandom_range(16, 32));
            if (nl >= 16 && nr >= 16) exp_q.push_back({top16(lw, nl), top16(rw, nr)});
            else fe_exp = 1'b1;
            send_frame(lw, nl, rw, nr);
        end
        close_stream();
        check("rnd_cnt", got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            check($sformatf("rnd_frame%0d", i), got[i], exp_q[i]);
        end
        check("rnd_err", frame_err, fe_exp);
        check("rnd_ovr", overrun, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
